seg7_updown_counter: RTL and testbench

SEG7_UPDOWN_COUNTER -- requirements
Module: seg7_updown_counter

---
 rtl/seg7_updown_counter.sv | 143 ++++++++++++++
 tb/tb_seg7_updown_counter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seg7_updown_counter                                          |
// | Description : Two-digit BCD up/down counter (00..99, saturating) with a     |
// |               tick prescaler, terminal-count pulse and a 2-digit           |
// |               multiplexed active-low 7-segment display driver.             |
// |               Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks a zero tens  |
// |               digit on the display.                                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seg7_updown_counter #(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       forward,
    output logic       finish,
    output logic [7:0] count_bcd,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] C_PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] C_SCAN_MAX  = SW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [SW-1:0] scan_q, scan_d;
    logic [3:0]    units_q, units_d;
    logic [3:0]    tens_q, tens_d;
    logic          finish_q, finish_d;
    logic          sel_q, sel_d;
    logic          run_q, run_d;

    logic          w_tick;
    logic          w_up_ok;
    logic          w_dn_ok;
    logic [3:0]    w_digit;
    logic [6:0]    w_pattern;

    always_comb begin
        w_tick   = enable && (presc_q == C_PRESC_MAX);
        w_up_ok  = forward && !((tens_q == 4'd9) && (units_q == 4'd9));
        w_dn_ok  = !forward && !((tens_q == 4'd0) && (units_q == 4'd0));

        // A dropped enable discards the partial period so the next run restarts cleanly
        presc_d  = '0;
        if (enable && !w_tick) begin
            presc_d = presc_q + PW'(1);
        end

        units_d  = units_q;
        tens_d   = tens_q;
        finish_d = 1'b0;
        if (w_tick && w_up_ok) begin
            if (units_q == 4'd9) begin
                units_d = 4'd0;
                tens_d  = tens_q + 4'd1;
            end else begin
                units_d = units_q + 4'd1;
            end
            finish_d = (tens_d == 4'd9) && (units_d == 4'd9);
        end else if (w_tick && w_dn_ok) begin
            if (units_q == 4'd0) begin
                units_d = 4'd9;
                tens_d  = tens_q - 4'd1;
            end else begin
                units_d = units_q - 4'd1;
            end
            finish_d = (tens_d == 4'd0) && (units_d == 4'd0);
        end

        // Scan counter waits one cycle after reset so the units slot gets its full length
        run_d  = 1'b1;
        scan_d = scan_q;
        sel_d  = sel_q;
        if (run_q) begin
            if (scan_q == C_SCAN_MAX) begin
                scan_d = '0;
                sel_d  = !sel_q;
            end else begin
                scan_d = scan_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q  <= '0;
            scan_q   <= '0;
            units_q  <= 4'd0;
            tens_q   <= 4'd0;
            finish_q <= 1'b0;
            sel_q    <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            scan_q   <= scan_d;
            units_q  <= units_d;
            tens_q   <= tens_d;
            finish_q <= finish_d;
            sel_q    <= sel_d;
            run_q    <= run_d;
        end
    end

    always_comb begin
        w_digit = sel_q ? tens_q : units_q;
        case (w_digit)
            4'd0:    w_pattern = 7'b1000000;
            4'd1:    w_pattern = 7'b1111001;
            4'd2:    w_pattern = 7'b0100100;
            4'd3:    w_pattern = 7'b0110000;
            4'd4:    w_pattern = 7'b0011001;
            4'd5:    w_pattern = 7'b0010010;
            4'd6:    w_pattern = 7'b0000010;
            4'd7:    w_pattern = 7'b1111000;
            4'd8:    w_pattern = 7'b0000000;
            4'd9:    w_pattern = 7'b0010000;
            default: w_pattern = 7'b1111111;
        endcase
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (sel_q && (tens_q == 4'd0)) begin
            w_pattern = 7'b1111111;
        end
`endif
        if (!run_q) begin
            an  = 2'b11;
            seg = 7'b1111111;
        end else begin
            an  = sel_q ? 2'b01 : 2'b10;
            seg = w_pattern;
        end
    end

    assign finish    = finish_q;
    assign count_bcd = {tens_q, units_q};

endmodule
`default_nettype wire

// File: tb/tb_seg7_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_seg7_updown_counter                                       |
// | Description : Self-checking bench for seg7_updown_counter against an       |
// |               integer-level reference model, directed plus random phases.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_seg7_updown_counter;

    localparam int TICK_DIV = 4;
    localparam int SCAN_DIV = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       forward = 1'b1;
    logic       finish;
    logic [7:0] count_bcd;
    logic [6:0] seg;
    logic [1:0] an;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: plain integers
    int m_cnt = 0;
    int m_phase = 0;
    int m_fin = 0;
    int m_run = 0;
    int m_t = 0;

    logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    seg7_updown_counter #(
        .TICK_DIV (TICK_DIV),
        .SCAN_DIV (SCAN_DIV)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .forward   (forward),
        .finish    (finish),
        .count_bcd (count_bcd),
        .seg       (seg),
        .an        (an)
    );

    always #5 clk = !clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_cnt = 0; m_phase = 0; m_fin = 0; m_run = 0; m_t = 0;
        end else begin
            m_fin = 0;
            if (enable) begin
                m_phase++;
                if (m_phase == TICK_DIV) begin
                    m_phase = 0;
                    if (forward && m_cnt < 99) begin
                        m_cnt++;
                        m_fin = (m_cnt == 99);
                    end else if (!forward && m_cnt > 0) begin
                        m_cnt--;
                        m_fin = (m_cnt == 0);
                    end
                end
            end else begin
                m_phase = 0;
            end
            if (m_run != 0) m_t++;
            else begin
                m_run = 1;
                m_t = 0;
            end
        end
    endtask

    function automatic logic [7:0] exp_bcd();
        return {4'(m_cnt / 10), 4'(m_cnt % 10)};
    endfunction

    function automatic logic [1:0] exp_an();
        if (m_run == 0) return 2'b11;
        return (((m_t / SCAN_DIV) % 2) == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [6:0] exp_seg();
        bit tens_slot;
        if (m_run == 0) return 7'b1111111;
        tens_slot = (((m_t / SCAN_DIV) % 2) == 1);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (tens_slot && (m_cnt / 10) == 0) return 7'b1111111;
`endif
        return tens_slot ? seg_tbl[m_cnt / 10] : seg_tbl[m_cnt % 10];
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("count_bcd", count_bcd, exp_bcd());
        check("finish", {7'd0, finish}, 8'(m_fin));
        check("an", {6'd0, an}, {6'd0, exp_an()});
        check("seg", {1'b0, seg}, {1'b0, exp_seg()});
    endtask

    task automatic run(input int n, input logic en, input logic fw);
        enable = en;
        forward = fw;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int guard;
        int pulses;

        reset = 1'b1;
        run(3, 1'b1, 1'b1);
        reset = 1'b0;

        // Full sweep up, count terminal pulses seen
        pulses = 0;
        enable = 1'b1; forward = 1'b1;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (finish === 1'b1) pulses++;
        end
        check("up_pulses", 8'(pulses), 8'd1);
        check("up_final", count_bcd, 8'h99);

        pulses = 0;
        enable = 1'b1; forward = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cycle();
            if (finish === 1'b1) pulses++;
        end
        check("dn_pulses", 8'(pulses), 8'd1);
        check("dn_final", count_bcd, 8'h00);

        // Enable dropped two cycles into a period, then re-raised
        run(4, 1'b1, 1'b1);
        run(2, 1'b1, 1'b1);
        run(3, 1'b0, 1'b1);
        run(3, 1'b1, 1'b1);
        check("no_early_step", count_bcd, 8'h01);
        run(1, 1'b1, 1'b1);
        check("step_after_reraise", count_bcd, 8'h02);

        // Reach 05 and watch the display scan
        guard = 0;
        enable = 1'b1; forward = 1'b1;
        while (m_cnt != 5 && guard < 200) begin
            cycle();
            guard++;
        end
        run(8, 1'b0, 1'b1);
        check("hold05", count_bcd, 8'h05);

        // Reset asserted in the tick cycle that would leave 57
        guard = 0;
        enable = 1'b1; forward = 1'b1;
        while (!(m_cnt == 57 && m_phase == TICK_DIV - 1) && guard < 1000) begin
            cycle();
            guard++;
        end
        check("reach57", 8'(guard < 1000), 8'd1);
        reset = 1'b1;
        cycle();
        check("rst_count", count_bcd, 8'h00);
        check("rst_an", {6'd0, an}, 8'h03);
        reset = 1'b0;

        // Random phase with occasional reset
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 39) == 0) forward = !forward;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
